// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default fetch constants and the instruction-fetch state encoding.
package cpu_pkg;

    localparam logic [31:0] CPU_NOP_INST = 32'h0000_0013;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request, a one-entry skid buffer for
// stalled responses, and registered instruction/PC outputs towards the IF/ID register.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC,
    parameter logic [31:0] NOP_INST = CPU_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    logic        deliver;
    logic [31:0] deliver_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // redirect always wins; a request already on the bus must be drained in DROP
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ: begin
                state_d = redirect ? DROP : WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    state_d = stall ? HOLD : REQ;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_d = REQ;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        if (state_q == REQ && !rst) begin
            imem_req = 1'b1;
        end
    end

    assign imem_addr = pc_q;

    assign deliver = !redirect && !stall &&
                     ((state_q == WAIT && imem_rvalid) || (state_q == HOLD && hold_valid_q));
    assign deliver_inst = (state_q == HOLD) ? hold_inst_q : imem_rdata;

    always_comb begin
        pc_d         = pc_q;
        hold_inst_d  = hold_inst_q;
        hold_valid_d = hold_valid_q;
        inst_d       = inst_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        if (redirect) begin
            pc_d         = redirect_pc;
            hold_valid_d = 1'b0;
            inst_d       = NOP_INST;
            pc_out_d     = 32'h0000_0000;
            valid_d      = 1'b0;
        end else if (stall) begin
            if (state_q == WAIT && imem_rvalid) begin
                hold_inst_d  = imem_rdata;
                hold_valid_d = 1'b1;
            end
        end else if (deliver) begin
            inst_d       = deliver_inst;
            pc_out_d     = pc_q;
            valid_d      = 1'b1;
            pc_d         = pc_q + 32'd4;
            hold_valid_d = 1'b0;
        end else begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            hold_inst_q  <= 32'h0000_0000;
            hold_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            pc_out_q     <= 32'h0000_0000;
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            hold_inst_q  <= hold_inst_d;
            hold_valid_q <= hold_valid_d;
            inst_q       <= inst_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
        end
    end

    assign inst_out  = inst_q;
    assign pc_out    = pc_out_q;
    assign valid_out = valid_q;

endmodule
